// File: rtl/cdc_handshake_tx_if.sv
// Handshake bundle for the source end of a toggle request/acknowledge
// clock-domain crossing. The slave modport is the transmitter's view; the
// master modport is the view of whatever feeds words and returns ACK_IN.
interface cdc_handshake_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] DIN;
  logic                  DIN_VALID;
  logic                  DIN_READY;
  logic [DATA_WIDTH-1:0] DATA_OUT;
  logic                  REQ_OUT;
  logic                  ACK_IN;
  logic                  BUSY;
  logic                  ERR;

  modport master (
    output DIN, DIN_VALID, ACK_IN,
    input  DIN_READY, DATA_OUT, REQ_OUT, BUSY, ERR
  );

  modport slave (
    input  DIN, DIN_VALID, ACK_IN,
    output DIN_READY, DATA_OUT, REQ_OUT, BUSY, ERR
  );
endinterface

// File: rtl/cdc_handshake_tx.sv
// Source end of a two-phase (toggle) request/acknowledge CDC. A word is taken
// on a valid/ready handshake, held on DATA_OUT, and announced by toggling
// REQ_OUT. The returning ACK_IN toggle is synchronized locally; the next word
// is only taken once the synchronized acknowledge matches REQ_OUT again.
// SYNC_STAGES must lie in 2..4.
module cdc_handshake_tx #(
  parameter int DATA_WIDTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               CLK_0,
  input  logic               RST_0,
  cdc_handshake_tx_if.slave  bus
);

  // A zero timeout disables the watchdog; keep a 1-bit counter so the logic
  // stays well formed, and never let it move.
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam int CNT_W = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_EN ? (TIMEOUT_CYCLES - 1) : 0);

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_WAIT_ACK = 1'b1
  } state_t;

  state_t                  state_r;
  state_t                  state_s;
  logic [SYNC_STAGES-1:0]  ack_sync_r;
  logic                    ack_s;
  logic [DATA_WIDTH-1:0]   data_r;
  logic                    req_r;
  logic [CNT_W-1:0]        cnt_r;
  logic [CNT_W-1:0]        cnt_s;
  logic                    err_r;
  logic                    err_s;
  logic                    din_ready_r;
  logic                    busy_r;
  logic                    accept_s;

  assign ack_s = ack_sync_r[SYNC_STAGES-1];

  // ACK_IN synchronizer: the only logic that touches the asynchronous input.
  always_ff @(posedge CLK_0) begin
    if (RST_0) begin
      ack_sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      ack_sync_r <= {ack_sync_r[SYNC_STAGES-2:0], bus.ACK_IN};
    end
  end

  // Next-state, accept strobe, timeout counter and sticky error decode.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    cnt_s    = cnt_r;
    err_s    = err_r;
    case (state_r)
      ST_IDLE: begin
        // din_ready_r is low in the first cycle out of reset, which holds
        // off an accept until DIN_READY has actually been shown high.
        if (din_ready_r && bus.DIN_VALID) begin
          accept_s = 1'b1;
          state_s  = ST_WAIT_ACK;
          cnt_s    = {CNT_W{1'b0}};
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_WAIT_ACK: begin
        if (TO_EN && (cnt_r == CNT_LAST)) begin
          err_s = 1'b1;
        end else begin
          err_s = err_r;
        end
        // Timeout never forces an exit: leaving early would break REQ/ACK
        // parity with the destination end.
        if (ack_s == req_r) begin
          state_s = ST_IDLE;
        end else if (TO_EN && (cnt_r != CNT_MAX)) begin
          state_s = ST_WAIT_ACK;
          cnt_s   = cnt_r + CNT_W'(1);
        end else begin
          state_s = ST_WAIT_ACK;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, held word, request toggle and registered status outputs.
  always_ff @(posedge CLK_0) begin
    if (RST_0) begin
      state_r     <= ST_IDLE;
      data_r      <= {DATA_WIDTH{1'b0}};
      req_r       <= 1'b0;
      cnt_r       <= {CNT_W{1'b0}};
      err_r       <= 1'b0;
      din_ready_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      err_r       <= err_s;
      din_ready_r <= (state_s == ST_IDLE);
      busy_r      <= (state_s == ST_WAIT_ACK);
      if (accept_s) begin
        data_r <= bus.DIN;
        req_r  <= ~req_r;
      end else begin
        data_r <= data_r;
        req_r  <= req_r;
      end
    end
  end

  assign bus.DIN_READY = din_ready_r;
  assign bus.BUSY      = busy_r;
  assign bus.DATA_OUT  = data_r;
  assign bus.REQ_OUT   = req_r;
  assign bus.ERR       = err_r;

endmodule

// File: doc/cdc_handshake_tx.md
# cdc_handshake_tx

Source end of a two-phase (toggle) request/acknowledge clock-domain crossing. Accepts a data word on a valid/ready interface in the CLK_0 domain, holds it stable on DATA_OUT, and signals it by toggling REQ_OUT. The destination domain samples REQ_OUT through a two-flop synchronizer, captures DATA_OUT, and toggles ACK_IN back. This block synchronizes ACK_IN internally and only accepts the next word once the acknowledge has returned.

## Interface
Parameters:
- DATA_WIDTH, 8: width of DIN/DATA_OUT.
- SYNC_STAGES, 2: flops in the ACK_IN synchronizer; legal range 2–4.
- TIMEOUT_CYCLES, 1024: WAIT_ACK cycles before ERR is set; 0 disables the timeout.

Ports:
- CLK_0  in  1  single clock; all logic on rising edge.
- RST_0  in  1  synchronous, active-high reset.
- DIN  in  DATA_WIDTH  word to transfer.
- DIN_VALID  in  1  DIN is valid.
- DIN_READY  out  1  block can accept a word this cycle.
- DATA_OUT  out  DATA_WIDTH  registered word held for the destination domain.
- REQ_OUT  out  1  registered request toggle; one toggle per transfer.
- ACK_IN  in  1  asynchronous acknowledge toggle from the destination domain.
- BUSY  out  1  transfer in flight (state WAIT_ACK).
- ERR  out  1  sticky: acknowledge not returned within TIMEOUT_CYCLES.

## Operation
- ACK_IN passes through SYNC_STAGES flops (reset 0). ack_s is the last stage. No other logic reads ACK_IN directly.
- FSM states:
  - IDLE: DIN_READY = 1. If DIN_VALID is high: DATA_OUT <= DIN, REQ_OUT <= ~REQ_OUT, timeout counter <= 0, go to WAIT_ACK.
  - WAIT_ACK: DIN_READY = 0, BUSY = 1. If ack_s == REQ_OUT, go to IDLE. Otherwise increment the timeout counter, saturating.
- ERR is set when the counter reaches TIMEOUT_CYCLES−1 while still in WAIT_ACK. ERR is cleared only by RST_0.
- The FSM does not leave WAIT_ACK on timeout. REQ/ACK parity must never be broken.
- DATA_OUT and REQ_OUT change only on the acceptance edge. Both are stable for the whole of WAIT_ACK.
- DIN_VALID while DIN_READY = 0 is ignored. No word is stored and there is no error.
- ACK_IN toggles while in IDLE (spurious, ack_s != REQ_OUT): the next accept still proceeds. WAIT_ACK then exits when ack_s == REQ_OUT. No special handling.
- DIN_READY and BUSY are decoded from state only and have no combinational path from DIN_VALID or ACK_IN.
- Timeout counter width: $clog2(TIMEOUT_CYCLES+1). The counter is held at 0 when TIMEOUT_CYCLES = 0.

## Timing
- Reset (RST_0 high at an edge):
  - State = IDLE.
  - REQ_OUT = 0, DATA_OUT = 0, ack synchronizer = 0, counter = 0, ERR = 0, BUSY = 0.
  - DIN_READY = 0 while RST_0 is high, and 1 from the first cycle after reset deasserts.
- Reset mid-transfer returns REQ_OUT to 0 immediately. The destination end must be reset in the same reset window.
- Accept at edge N: REQ_OUT, DATA_OUT and BUSY are updated after edge N, and DIN_READY = 0 from N.
- ACK_IN toggles before edge K: ack_s updates after edge K+SYNC_STAGES−1. The FSM returns to IDLE at edge K+SYNC_STAGES, and DIN_READY = 1 after that edge.
- Minimum spacing between accepts, with zero destination latency: 1 + SYNC_STAGES + 1 cycles.
- Throughput: one word per round trip.

## Test plan
- Reset: hold RST_0 high for 3 cycles with DIN_VALID = 1 and ACK_IN = 1. Required response: REQ_OUT = 0, DATA_OUT = 0, DIN_READY = 0, BUSY = 0, ERR = 0. Release reset: DIN_READY = 1 on the next cycle.
- Single transfer with DIN = 0xA5 and an ACK model that toggles ACK_IN 3 cycles after seeing REQ_OUT change:
  - REQ_OUT goes 0→1 and DATA_OUT = 0xA5 after the accept edge.
  - BUSY stays high until SYNC_STAGES+1 edges after the ACK toggle.
  - DATA_OUT is stable throughout; DIN_READY then returns to 1.
- Back-to-back: DIN_VALID held high with DIN = 0x01, 0x02, 0x03. Required response:
  - Exactly three REQ_OUT toggles (0→1→0→1).
  - DATA_OUT sequence is 0x01, 0x02, 0x03.
  - No word is accepted while BUSY.
- Valid while busy: change DIN to 0xFF mid-WAIT_ACK. Required response: DATA_OUT keeps the old word, and 0xFF is accepted only after the return to IDLE.
- Timeout with TIMEOUT_CYCLES = 16 and ACK_IN withheld:
  - ERR = 1 after 16 WAIT_ACK cycles; BUSY stays 1.
  - A late ACK toggle returns the FSM to IDLE while ERR stays 1.
  - RST_0 clears ERR.
- Reset mid-transfer: assert RST_0 during WAIT_ACK. Required response: REQ_OUT = 0 and state IDLE; a subsequent transfer toggles REQ_OUT 0→1.
